// File: rtl/tanh_pkg.sv
// Shared constants and types for the tanh lookup table block.
// Optional checksum feature: TANH_LUT_CHECKSUM_EN.
package tanh_pkg;

  // Q16.16 fixed-point constants
  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] Q_ONE     = 32'h0001_0000;
  localparam logic [31:0] Q_NEG_ONE = 32'hFFFF_0000;

  // LUT geometry
  localparam int LUT_ADDR_W = 10;
  localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;

  // Width of the running load checksum (modulo 2^32)
  localparam int CSUM_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/tanh_lut_ram.sv
// Table storage: one write port, NRD synchronous read ports.
// Each read port owns a full copy of the table; all copies are written together,
// so every copy maps onto a simple 1W/1R block RAM.
module tanh_lut_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NRD    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        re,
  input  logic [NRD-1:0][ADDR_W-1:0]  raddr,
  output logic [NRD-1:0][DATA_W-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar g = 0; g < NRD; g++) begin : g_copy
    logic [DATA_W-1:0] mem [DEPTH];

    // Shared write into this copy; contents are never cleared by reset
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    // Registered read; output holds when no read is issued
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata[g] <= '0;
      else if (re) rdata[g] <= mem[raddr[g]];
    end
  end

endmodule

// File: rtl/tanh_lut_loader.sv
// Loader and interpolation read port for the 1024 x Q16.16 tanh table.
// Optional macro TANH_LUT_CHECKSUM_EN: after the last table word, one extra
// stream word carries the modulo-2^32 sum of the table; mismatch -> ERR.
module tanh_lut_loader
  import tanh_pkg::*;
#(
  parameter int DATA_W = 2 * FRAC_BITS,
  parameter int ADDR_W = LUT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid,
  output logic              table_ready,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int            DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_e                    state;
  logic                      hs;
  logic                      we;
  logic                      last_slot;
  logic                      rd_fire;
  logic [1:0][ADDR_W-1:0]    raddr;
  logic [1:0][DATA_W-1:0]    rdata;

`ifdef TANH_LUT_CHECKSUM_EN
  logic [CSUM_W-1:0]         csum;
  assign s_ready = (state == LOAD) || (state == CHK);
`else
  assign s_ready = (state == LOAD);
`endif

  // start wins over a same-cycle handshake: that word is dropped
  assign hs        = s_valid & s_ready & ~start;
  assign we        = hs & (state == LOAD);
  assign last_slot = (word_count == LAST_IDX);
  assign rd_fire   = rd_en & table_ready;

  // idx+1 saturates at the top entry instead of wrapping to 0
  assign raddr[0] = rd_addr;
  assign raddr[1] = (rd_addr == '1) ? rd_addr : rd_addr + 1'b1;
  assign rd_data0 = rdata[0];
  assign rd_data1 = rdata[1];

  tanh_lut_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NRD    (2)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (word_count[ADDR_W-1:0]),
    .wdata (s_data),
    .re    (rd_fire),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Load FSM with registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_count  <= '0;
      table_ready <= 1'b0;
      load_err    <= 1'b0;
`ifdef TANH_LUT_CHECKSUM_EN
      csum        <= '0;
`endif
    end else if (start) begin
      state       <= LOAD;
      word_count  <= '0;
      table_ready <= 1'b0;
      load_err    <= 1'b0;
`ifdef TANH_LUT_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        LOAD: if (hs) begin
          word_count <= word_count + 1'b1;
`ifdef TANH_LUT_CHECKSUM_EN
          csum       <= csum + CSUM_W'(s_data);
`endif
          if (s_last && last_slot) begin
`ifdef TANH_LUT_CHECKSUM_EN
            state       <= CHK;
`else
            state       <= DONE;
            table_ready <= 1'b1;
`endif
          end else if (s_last || last_slot) begin
            // early s_last, or a full table without s_last
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
`ifdef TANH_LUT_CHECKSUM_EN
        CHK: if (hs) begin
          if (csum == CSUM_W'(s_data)) begin
            state       <= DONE;
            table_ready <= 1'b1;
          end else begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
`endif
        default: state <= state;
      endcase
    end
  end

  // One-cycle read valid, only for honoured requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= rd_fire;
  end

endmodule

// File: tb/tb_tanh_lut_loader.sv
// Directed bench for tanh_lut_loader. Compile with +define+TANH_LUT_CHECKSUM_EN
// to exercise the checksum word.
module tb_tanh_lut_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid, table_ready, load_err;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;

  tanh_lut_loader #(.DATA_W(32), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .rd_valid    (rd_valid),
    .table_ready (table_ready),
    .load_err    (load_err),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one word for one cycle; returns at the following negedge
  task automatic send(input logic [31:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full table load of value i*mul+add, plus checksum word when enabled
  task automatic full_load(input logic [31:0] mul, input logic [31:0] add, input logic [31:0] csum_bias);
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < 1024; i++) begin
      send(32'(i) * mul + add, i == 1023);
      sum += 32'(i) * mul + add;
    end
`ifdef TANH_LUT_CHECKSUM_EN
    send(sum + csum_bias, 1'b0);
`else
    sum = sum + csum_bias;
`endif
  endtask

  task automatic read(input logic [9:0] a);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_table_ready", table_ready, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_rd_data0", rd_data0, 0);
    chk("rst_rd_data1", rd_data1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 0);

    // full load mem[i] = i*16
    pulse_start();
    chk("load_s_ready", s_ready, 1);
    chk("load_wc0", word_count, 0);
    full_load(32'd16, 32'd0, 32'd0);
    chk("full_table_ready", table_ready, 1);
    chk("full_word_count", word_count, 1024);
    chk("full_load_err", load_err, 0);
    chk("full_s_ready", s_ready, 0);

    // interpolation read at 5
    read(10'd5);
    chk("rd5_valid", rd_valid, 1);
    chk("rd5_d0", rd_data0, 80);
    chk("rd5_d1", rd_data1, 96);
    @(negedge clk);
    chk("rd5_valid_drop", rd_valid, 0);
    chk("rd5_d0_hold", rd_data0, 80);

    // back-to-back: top boundary then index 0
    rd_en = 1'b1; rd_addr = 10'd1023;
    @(negedge clk);
    chk("rd1023_valid", rd_valid, 1);
    chk("rd1023_d0", rd_data0, 16368);
    chk("rd1023_d1", rd_data1, 16368);
    rd_addr = 10'd0;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd0_valid", rd_valid, 1);
    chk("rd0_d0", rd_data0, 0);
    chk("rd0_d1", rd_data1, 16);

    // short load: s_last on word 100 (101 words)
    pulse_start();
    chk("short_tr_cleared", table_ready, 0);
    for (int i = 0; i <= 100; i++) send(32'd1000 + 32'(i), i == 100);
    chk("short_load_err", load_err, 1);
    chk("short_table_ready", table_ready, 0);
    chk("short_s_ready", s_ready, 0);
    chk("short_word_count", word_count, 101);
    read(10'd3);
    chk("short_rd_valid", rd_valid, 0);
    chk("short_rd_hold", rd_data1, 16);

    // restart mid-load, same-cycle handshake ignored
    pulse_start();
    chk("restart_err_clr", load_err, 0);
    for (int i = 0; i < 500; i++) send(32'd99, 1'b0);
    chk("mid_word_count", word_count, 500);
    start = 1'b1; s_valid = 1'b1; s_data = 32'd55;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0;
    chk("restart_wc0", word_count, 0);
    chk("restart_s_ready", s_ready, 1);
    full_load(32'd0, 32'd7, 32'd0);
    chk("restart_table_ready", table_ready, 1);
    chk("restart_word_count", word_count, 1024);
    read(10'd0);
    chk("r7_0_d0", rd_data0, 7);
    chk("r7_0_d1", rd_data1, 7);
    read(10'd600);
    chk("r7_600_d0", rd_data0, 7);
    chk("r7_600_d1", rd_data1, 7);

    // async reset mid-load
    pulse_start();
    for (int i = 0; i < 300; i++) send(32'd5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_word_count", word_count, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_table_ready", table_ready, 0);
    chk("arst_rd_data0", rd_data0, 0);
    chk("arst_rd_valid", rd_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    full_load(32'd3, 32'd1, 32'd0);
    chk("post_rst_table_ready", table_ready, 1);
    chk("post_rst_load_err", load_err, 0);
    read(10'd2);
    chk("post_rst_d0", rd_data0, 7);
    chk("post_rst_d1", rd_data1, 10);
    read(10'd1022);
    chk("post_rst_hi_d0", rd_data0, 3067);
    chk("post_rst_hi_d1", rd_data1, 3070);

`ifdef TANH_LUT_CHECKSUM_EN
    // wrong checksum word
    pulse_start();
    full_load(32'd2, 32'd0, 32'd1);
    chk("csum_bad_err", load_err, 1);
    chk("csum_bad_ready", table_ready, 0);
    chk("csum_bad_s_ready", s_ready, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
